bfu_core: RTL and testbench
===========================

# bfu_core

Synchronous, parametrised BrainFuck execution core that succeeds the original edge-triggered unit. It fetches ASCII opcodes from an internally held code memory, executes against a zero-initialised data memory, and resolves `[`/`]` with an optional hardware loop stack. It talks to the rest of the design through a code-load write port and valid/ready byte streams for `,` and `.`.

## Interface
- `BITSIZE`, 8: cell, opcode and stream byte width.
- `STKSIZE`, 12: loop-stack depth, i.e. the maximum `[` nesting.
- `DADDLEN`, 10: data address width; the data memory has 2^DADDLEN cells.
- `CADDLEN`, 10: code address width; the code memory has 2^CADDLEN bytes.
- `CLK` in 1: the single clock; all logic is on the rising edge.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle request to begin execution; accepted in IDLE only.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse on normal halt.
- `ERR` out 1 and `ERRCODE` out 2: sticky error flag and code. Codes: 1 = stack overflow, 2 = unmatched `]`, 3 = unmatched `[`.
- `CWE` in 1, `CWA` in CADDLEN, `CWD` in BITSIZE: code-memory write port, accepted only while BUSY = 0.
- `IDAT` in BITSIZE, `IVLD` in 1, `IRDY` out 1: input stream.
- `ODAT` out BITSIZE, `OVLD` out 1, `ORDY` in 1: output stream.

## Operation
- Opcode encoding:
  - `+` 0x2B, `-` 0x2D, `>` 0x3E, `<` 0x3C, `.` 0x2E, `,` 0x2C, `[` 0x5B, `]` 0x5D.
  - 0x00 halts.
  - Every other byte is a NOP.
- States: IDLE, CLEAR, FETCH, EXEC, SKIPF, SKIPB, INWAIT, OUTWAIT, FAULT.
- IDLE + START: clear pc, dp, stack and ERR; go to CLEAR.
- CLEAR: write 0 to one data cell per cycle, 2^DADDLEN cycles, then go to FETCH.
- FETCH: present pc to the code memory (synchronous read). EXEC then decodes the returned byte.
- Arithmetic and pointer rules:
  - `+` and `-` are modulo 2^BITSIZE.
  - `>` and `<` move dp modulo 2^DADDLEN; wrap is silent.
  - pc reaching 2^CADDLEN−1 without a 0x00 halts after executing that byte.
- `.` enters OUTWAIT. OVLD = 1 and ODAT = cell, held stable until OVLD && ORDY, then pc+1 and FETCH.
- `,` enters INWAIT. IRDY = 1 until IVLD && IRDY; the cell is then written with IDAT, then pc+1 and FETCH.
- `[` with cell = 0: enter SKIPF with depth = 1.
  - Scan forward, one byte per FETCH/EXEC pair: `[` depth+1, `]` depth−1.
  - At depth 0, resume at the matching `]` + 1.
  - Hitting 0x00 or the end of code goes to FAULT with code 3.
- `[` with cell ≠ 0: push pc when the stack is enabled (see Configuration), then pc+1. A push into a full stack goes to FAULT with code 1.
- `]` with cell = 0: pop (stack build), then pc+1.
- `]` with cell ≠ 0: jump to top+1 (stack build) or run the SKIPB backward scan (no-stack build). An empty stack, or scanning below address 0, goes to FAULT with code 2.
- Halt (0x00): pulse DONE, go to IDLE.
- FAULT: set ERR and ERRCODE, go to IDLE. ERR holds until RST or the next START.
- CWE while BUSY is ignored. The code memory is never reset. The data memory is cleared only by CLEAR.

## Timing
- Reset values: BUSY, DONE, ERR, IRDY and OVLD are 0; ERRCODE and ODAT are 0; pc, dp and stack pointer are 0. Reset takes effect mid-instruction: any pending I/O handshake is abandoned.
- START to first FETCH: 1 + 2^DADDLEN cycles.
- Non-I/O opcodes: 2 cycles each (FETCH, EXEC). A stack jump costs no extra cycles. Each scanned byte in SKIPF/SKIPB costs 2 cycles.
- I/O: earliest transfer is in the cycle after EXEC. Completion is the cycle in which valid && ready.
- RST and START in the same cycle: RST wins.

## Configuration
- `BFU_LOOPSTACK_EN` defined: the STKSIZE-entry loop stack is built; backward `]` resolves in 2 cycles; error code 1 is possible.
- Undefined: no stack; backward jumps use SKIPB scanning; code 1 never occurs; nesting depth is limited only by the CADDLEN-bit depth counter.

## Structure
- Shared package `bfu_pkg`: opcode constants, state enum, ERRCODE values.
- Sub-module `bfu_loop_stack`, instantiated only under the macro. Ports: push, pop, top, full, empty; depth STKSIZE, width CADDLEN.

## Test plan
- Load `+++.` then 0x00, START → ODAT = 0x03 on one beat, then DONE.
- `++[->+++<]>.` → ODAT = 0x06; ERR stays 0 in both macro builds.
- `[+++]+.` → skip taken, ODAT = 0x01.
- `,+.` with IDAT = 0x41 and ORDY held low 5 cycles → OVLD high and ODAT = 0x42 stable all 5 cycles; a single transfer.
- `-.` → 0xFF. `<+.` → cell 2^DADDLEN−1 incremented, 0x01.
- Error and reset cases:
  - `]` → ERRCODE = 2.
  - `+` followed by STKSIZE+1 `[` → ERRCODE = 1 (stack build).
  - `[` with no `]` → ERRCODE = 3.
  - RST during OUTWAIT → OVLD = 0 next cycle, IDLE.

Source files
------------

// File: rtl/bfu_pkg.sv
// bfu_pkg: shared definitions for the bfu_core BrainFuck execution core.
//   - opcode byte constants
//   - FSM state enum and scan-mode enum
//   - ERRCODE values
package bfu_pkg;

  localparam logic [7:0] OpHalt  = 8'h00;
  localparam logic [7:0] OpInc   = 8'h2B;
  localparam logic [7:0] OpDec   = 8'h2D;
  localparam logic [7:0] OpRight = 8'h3E;
  localparam logic [7:0] OpLeft  = 8'h3C;
  localparam logic [7:0] OpOut   = 8'h2E;
  localparam logic [7:0] OpIn    = 8'h2C;
  localparam logic [7:0] OpOpen  = 8'h5B;
  localparam logic [7:0] OpClose = 8'h5D;

  localparam logic [1:0] ErrNone           = 2'd0;
  localparam logic [1:0] ErrOverflow       = 2'd1;
  localparam logic [1:0] ErrUnmatchedClose = 2'd2;
  localparam logic [1:0] ErrUnmatchedOpen  = 2'd3;

  typedef enum logic [3:0] {
    StIdle, StClear, StFetch, StExec, StSkipF, StSkipB, StInWait, StOutWait, StFault
  } state_t;

  // Which state FETCH hands the fetched byte to.
  typedef enum logic [1:0] {ScanNone, ScanFwd, ScanBwd} scan_t;

endpackage

// File: rtl/bfu_loop_stack.sv
// bfu_loop_stack: LIFO of loop-start code addresses, used only when BFU_LOOPSTACK_EN is defined.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   clr         : empty the stack (start of a new run)
//   push, din   : push din (ignored when full)
//   pop         : discard top entry (ignored when empty)
//   top         : current top entry ('0 when empty)
//   full, empty : occupancy flags
module bfu_loop_stack #(
  parameter int unsigned Depth = 12,
  parameter int unsigned Width = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int unsigned SpW  = $clog2(Depth + 1);
  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [SpW-1:0]   sp_q;
  logic [Width-1:0] mem_q [Depth];

  assign full  = (sp_q == SpW'(Depth));
  assign empty = (sp_q == '0);
  assign top   = empty ? '0 : mem_q[IdxW'(sp_q - SpW'(1))];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SpW'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SpW'(1);
    end
  end

  // Storage needs no reset: entries above sp are never observed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[IdxW'(sp_q)] <= din;
    end
  end

endmodule

// File: rtl/bfu_core.sv
// bfu_core: synchronous BrainFuck execution core.
// Optional feature macro: BFU_LOOPSTACK_EN builds the hardware loop stack (bfu_loop_stack);
// without it, backward ']' jumps scan the code memory (SKIPB).
// Ports:
//   CLK, RST (sync, active high), START   : control
//   BUSY, DONE, ERR, ERRCODE              : status (ERR/ERRCODE sticky until RST or START)
//   CWE, CWA, CWD                         : code-memory write port (IDLE only)
//   IDAT, IVLD, IRDY                      : ',' input stream
//   ODAT, OVLD, ORDY                      : '.' output stream
module bfu_core
  import bfu_pkg::*;
#(
  parameter int unsigned BITSIZE = 8,
  parameter int unsigned STKSIZE = 12,
  parameter int unsigned DADDLEN = 10,
  parameter int unsigned CADDLEN = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  output logic               BUSY,
  output logic               DONE,
  output logic               ERR,
  output logic [1:0]         ERRCODE,
  input  logic               CWE,
  input  logic [CADDLEN-1:0] CWA,
  input  logic [BITSIZE-1:0] CWD,
  input  logic [BITSIZE-1:0] IDAT,
  input  logic               IVLD,
  output logic               IRDY,
  output logic [BITSIZE-1:0] ODAT,
  output logic               OVLD,
  input  logic               ORDY
);

  // Opcodes are ASCII, so the byte width must hold them; the stack needs at least one entry.
  if (BITSIZE < 8 || STKSIZE < 1) begin : g_bad_cfg
    $error("bfu_core: BITSIZE must be >= 8 and STKSIZE >= 1");
  end

  localparam logic [CADDLEN-1:0] PcLast = '1;
  localparam logic [DADDLEN-1:0] DpLast = '1;

  state_t               state_q, state_d;
  scan_t                scan_q, scan_d;
  logic [CADDLEN-1:0]   pc_q, pc_d, depth_q, depth_d;
  logic [DADDLEN-1:0]   dp_q, dp_d;
  logic                 done_q, done_d, err_q, err_d;
  logic [1:0]           errcode_q, errcode_d, fcode_q, fcode_d;
  logic [BITSIZE-1:0]   code_q, cell_q;
  logic                 dwe, adv, fault;
  logic [BITSIZE-1:0]   dwd;
  logic [BITSIZE-1:0]   cmem [2**CADDLEN];
  logic [BITSIZE-1:0]   dmem [2**DADDLEN];

`ifdef BFU_LOOPSTACK_EN
  logic               stk_push, stk_pop, stk_clr, stk_full, stk_empty;
  logic [CADDLEN-1:0] stk_top;

  bfu_loop_stack #(
    .Depth(STKSIZE),
    .Width(CADDLEN)
  ) u_loop_stack (
    .clk  (CLK),
    .rst  (RST),
    .clr  (stk_clr),
    .push (stk_push),
    .pop  (stk_pop),
    .din  (pc_q),
    .top  (stk_top),
    .full (stk_full),
    .empty(stk_empty)
  );
`endif

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= StIdle;
      scan_q    <= ScanNone;
      pc_q      <= '0;
      dp_q      <= '0;
      depth_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      errcode_q <= ErrNone;
      fcode_q   <= ErrNone;
    end else begin
      state_q   <= state_d;
      scan_q    <= scan_d;
      pc_q      <= pc_d;
      dp_q      <= dp_d;
      depth_q   <= depth_d;
      done_q    <= done_d;
      err_q     <= err_d;
      errcode_q <= errcode_d;
      fcode_q   <= fcode_d;
    end
  end

  // Memories are never reset; reads are synchronous and happen only in FETCH.
  always_ff @(posedge CLK) begin
    if (CWE && state_q == StIdle) begin
      cmem[CWA] <= CWD;
    end
    if (state_q == StFetch) begin
      code_q <= cmem[pc_q];
      cell_q <= dmem[dp_q];
    end
    if (dwe && !RST) begin
      dmem[dp_q] <= dwd;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d   = state_q;
    scan_d    = scan_q;
    pc_d      = pc_q;
    dp_d      = dp_q;
    depth_d   = depth_q;
    done_d    = 1'b0;
    err_d     = err_q;
    errcode_d = errcode_q;
    fcode_d   = fcode_q;
    dwe       = 1'b0;
    dwd       = '0;
    adv       = 1'b0;
    fault     = 1'b0;
`ifdef BFU_LOOPSTACK_EN
    stk_push  = 1'b0;
    stk_pop   = 1'b0;
    stk_clr   = 1'b0;
`endif

    case (state_q)
      StIdle: begin
        if (START) begin
          pc_d      = '0;
          dp_d      = '0;
          scan_d    = ScanNone;
          err_d     = 1'b0;
          errcode_d = ErrNone;
`ifdef BFU_LOOPSTACK_EN
          stk_clr   = 1'b1;
`endif
          state_d   = StClear;
        end
      end
      StClear: begin
        // dp doubles as the clear counter and wraps back to 0 on the last cell.
        dwe  = 1'b1;
        dp_d = dp_q + DADDLEN'(1);
        if (dp_q == DpLast) state_d = StFetch;
      end
      StFetch: begin
        case (scan_q)
          ScanFwd: state_d = StSkipF;
          ScanBwd: state_d = StSkipB;
          default: state_d = StExec;
        endcase
      end
      StExec: begin
        case (code_q)
          BITSIZE'(OpHalt): begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
          BITSIZE'(OpInc): begin
            dwe = 1'b1;
            dwd = cell_q + BITSIZE'(1);
            adv = 1'b1;
          end
          BITSIZE'(OpDec): begin
            dwe = 1'b1;
            dwd = cell_q - BITSIZE'(1);
            adv = 1'b1;
          end
          BITSIZE'(OpRight): begin
            dp_d = dp_q + DADDLEN'(1);
            adv  = 1'b1;
          end
          BITSIZE'(OpLeft): begin
            dp_d = dp_q - DADDLEN'(1);
            adv  = 1'b1;
          end
          BITSIZE'(OpOut): state_d = StOutWait;
          BITSIZE'(OpIn):  state_d = StInWait;
          BITSIZE'(OpOpen): begin
            if (cell_q == '0) begin
              depth_d = CADDLEN'(1);
              scan_d  = ScanFwd;
              if (pc_q == PcLast) begin
                fault   = 1'b1;
                fcode_d = ErrUnmatchedOpen;
              end else begin
                pc_d    = pc_q + CADDLEN'(1);
                state_d = StFetch;
              end
            end else begin
`ifdef BFU_LOOPSTACK_EN
              if (stk_full) begin
                fault   = 1'b1;
                fcode_d = ErrOverflow;
              end else begin
                stk_push = 1'b1;
                adv      = 1'b1;
              end
`else
              adv = 1'b1;
`endif
            end
          end
          BITSIZE'(OpClose): begin
`ifdef BFU_LOOPSTACK_EN
            if (stk_empty) begin
              fault   = 1'b1;
              fcode_d = ErrUnmatchedClose;
            end else if (cell_q == '0) begin
              stk_pop = 1'b1;
              adv     = 1'b1;
            end else begin
              // Resume just past the '[' so it is not re-pushed.
              pc_d    = stk_top + CADDLEN'(1);
              state_d = StFetch;
            end
`else
            if (cell_q == '0) begin
              adv = 1'b1;
            end else if (pc_q == '0) begin
              fault   = 1'b1;
              fcode_d = ErrUnmatchedClose;
            end else begin
              depth_d = CADDLEN'(1);
              scan_d  = ScanBwd;
              pc_d    = pc_q - CADDLEN'(1);
              state_d = StFetch;
            end
`endif
          end
          default: adv = 1'b1;
        endcase
      end
      StSkipF: begin
        if (code_q == BITSIZE'(OpHalt)) begin
          fault   = 1'b1;
          fcode_d = ErrUnmatchedOpen;
        end else if (code_q == BITSIZE'(OpClose) && depth_q == CADDLEN'(1)) begin
          scan_d = ScanNone;
          adv    = 1'b1;
        end else begin
          if (code_q == BITSIZE'(OpOpen)) depth_d = depth_q + CADDLEN'(1);
          else if (code_q == BITSIZE'(OpClose)) depth_d = depth_q - CADDLEN'(1);
          if (pc_q == PcLast) begin
            fault   = 1'b1;
            fcode_d = ErrUnmatchedOpen;
          end else begin
            pc_d    = pc_q + CADDLEN'(1);
            state_d = StFetch;
          end
        end
      end
      StSkipB: begin
        if (code_q == BITSIZE'(OpOpen) && depth_q == CADDLEN'(1)) begin
          scan_d  = ScanNone;
          pc_d    = pc_q + CADDLEN'(1);
          state_d = StFetch;
        end else begin
          if (code_q == BITSIZE'(OpClose)) depth_d = depth_q + CADDLEN'(1);
          else if (code_q == BITSIZE'(OpOpen)) depth_d = depth_q - CADDLEN'(1);
          if (pc_q == '0) begin
            fault   = 1'b1;
            fcode_d = ErrUnmatchedClose;
          end else begin
            pc_d    = pc_q - CADDLEN'(1);
            state_d = StFetch;
          end
        end
      end
      StInWait: begin
        if (IVLD) begin
          dwe = 1'b1;
          dwd = IDAT;
          adv = 1'b1;
        end
      end
      StOutWait: begin
        if (ORDY) adv = 1'b1;
      end
      StFault: begin
        err_d     = 1'b1;
        errcode_d = fcode_q;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Step to the next byte; executing the last code address is an implicit halt.
    if (adv) begin
      if (pc_q == PcLast) begin
        done_d  = 1'b1;
        state_d = StIdle;
      end else begin
        pc_d    = pc_q + CADDLEN'(1);
        state_d = StFetch;
      end
    end
    if (fault) begin
      scan_d  = ScanNone;
      state_d = StFault;
    end
  end

  // Outputs.
  always_comb begin
    BUSY    = (state_q != StIdle);
    DONE    = done_q;
    ERR     = err_q;
    ERRCODE = errcode_q;
    IRDY    = (state_q == StInWait);
    OVLD    = (state_q == StOutWait);
    ODAT    = OVLD ? cell_q : '0;
  end

endmodule

// File: tb/tb_bfu_core.sv
module tb_bfu_core;

  localparam int unsigned BW = 8;
  localparam int unsigned SK = 12;
  localparam int unsigned DA = 10;
  localparam int unsigned CA = 10;
  localparam int NC = 1 << CA;
  localparam int ND = 1 << DA;

  logic          CLK = 1'b0;
  logic          RST, START, BUSY, DONE, ERR;
  logic [1:0]    ERRCODE;
  logic          CWE;
  logic [CA-1:0] CWA;
  logic [BW-1:0] CWD, IDAT, ODAT;
  logic          IVLD, IRDY, OVLD, ORDY;

  bfu_core #(
    .BITSIZE(BW),
    .STKSIZE(SK),
    .DADDLEN(DA),
    .CADDLEN(CA)
  ) dut (
    .CLK    (CLK),
    .RST    (RST),
    .START  (START),
    .BUSY   (BUSY),
    .DONE   (DONE),
    .ERR    (ERR),
    .ERRCODE(ERRCODE),
    .CWE    (CWE),
    .CWA    (CWA),
    .CWD    (CWD),
    .IDAT   (IDAT),
    .IVLD   (IVLD),
    .IRDY   (IRDY),
    .ODAT   (ODAT),
    .OVLD   (OVLD),
    .ORDY   (ORDY)
  );

  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  bit         check_en = 0;
  int         xfers;
  int         stall_seen;
  logic [7:0] first_xfer;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_odat = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Output-stream checker: every transfer against the model queue, stability while stalled.
  always @(negedge CLK) begin
    if (check_en) begin
      if (OVLD && prev_stall) check("odat stable while stalled", ODAT, prev_odat);
      if (OVLD && ORDY) begin
        if (exp_q.size() == 0) check("unexpected extra beat", 1, 0);
        else check("odat beat", ODAT, exp_q.pop_front());
        if (xfers == 0) first_xfer = ODAT;
        xfers++;
      end
      if (OVLD && !ORDY) stall_seen++;
      prev_stall = OVLD && !ORDY;
      prev_odat  = ODAT;
    end
  end

  // Reference interpreter: fills exp_q with the output bytes and returns the error code.
  task automatic model_run(input string prog, input logic [7:0] in_byte, output int err);
    logic [7:0] mc[NC];
    logic [7:0] md[ND];
    int         open[$];
    int         pc, dp, d;
    logic [7:0] c;
    foreach (mc[i]) mc[i] = 8'h00;
    foreach (md[i]) md[i] = 8'h00;
    for (int i = 0; i < prog.len(); i++) mc[i] = prog[i];
    pc = 0;
    dp = 0;
    err = 0;
    exp_q.delete();
    for (int steps = 0; steps < 200000; steps++) begin
      c = mc[pc];
      if (c == 8'h00) return;
      case (c)
        8'h2B: md[dp] = md[dp] + 8'd1;
        8'h2D: md[dp] = md[dp] - 8'd1;
        8'h3E: dp = (dp + 1) % ND;
        8'h3C: dp = (dp + ND - 1) % ND;
        8'h2E: exp_q.push_back(md[dp]);
        8'h2C: md[dp] = in_byte;
        8'h5B: begin
          if (md[dp] == 0) begin
            d = 1;
            while (d != 0) begin
              if (pc == NC - 1) begin err = 3; return; end
              pc++;
              if (mc[pc] == 8'h00) begin err = 3; return; end
              if (mc[pc] == 8'h5B) d++;
              else if (mc[pc] == 8'h5D) d--;
            end
          end
`ifdef BFU_LOOPSTACK_EN
          else if (open.size() == SK) begin err = 1; return; end
          else open.push_back(pc);
`endif
        end
        8'h5D: begin
`ifdef BFU_LOOPSTACK_EN
          if (open.size() == 0) begin err = 2; return; end
          if (md[dp] == 0) void'(open.pop_back());
          else pc = open[$];
`else
          if (md[dp] != 0) begin
            d = 1;
            while (d != 0) begin
              if (pc == 0) begin err = 2; return; end
              pc--;
              if (mc[pc] == 8'h5D) d++;
              else if (mc[pc] == 8'h5B) d--;
            end
          end
`endif
        end
        default: ;
      endcase
      if (pc == NC - 1) return;
      pc++;
    end
  endtask

  task automatic load(input string prog);
    for (int i = 0; i <= prog.len(); i++) begin
      @(negedge CLK);
      CWE = 1'b1;
      CWA = CA'(i);
      CWD = (i < prog.len()) ? prog[i] : 8'h00;
    end
    @(negedge CLK);
    CWE = 1'b0;
  endtask

  // Load, start, run to DONE or fault, then check final status against the model.
  task automatic run(input string name, input string prog, input logic [7:0] in_byte,
                     input int stall, input bit poke, output int cyc_ovld);
    int exp_err;
    bit fin;
    int stall_left;
    load(prog);
    model_run(prog, in_byte, exp_err);
    IDAT       = in_byte;
    IVLD       = 1'b1;
    ORDY       = 1'b1;
    xfers      = 0;
    stall_seen = 0;
    first_xfer = 8'hxx;
    stall_left = stall;
    cyc_ovld   = -1;
    fin        = 1'b0;
    check_en   = 1'b1;
    @(negedge CLK);
    START = 1'b1;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      @(posedge CLK);
      #1;
      if (cyc == 0) START = 1'b0;
      if (poke) begin
        if (cyc == 5) begin
          CWE = 1'b1;
          CWA = CA'(1);
          CWD = 8'h2D;
        end else begin
          CWE = 1'b0;
        end
      end
      if (OVLD && cyc_ovld < 0) cyc_ovld = cyc;
      if (OVLD && stall_left > 0) begin
        ORDY = 1'b0;
        stall_left--;
      end else begin
        ORDY = 1'b1;
      end
      if (DONE || (ERR && !BUSY)) fin = 1'b1;
    end
    @(negedge CLK);
    check_en = 1'b0;
    check({name, " terminated"}, fin, 1);
    check({name, " ERR"}, ERR, (exp_err != 0));
    check({name, " ERRCODE"}, ERRCODE, exp_err);
    check({name, " idle"}, BUSY, 0);
    check({name, " beats left"}, exp_q.size(), 0);
  endtask

  int c;

  initial begin
    RST   = 1'b1;
    START = 1'b0;
    CWE   = 1'b0;
    CWA   = '0;
    CWD   = '0;
    IDAT  = '0;
    IVLD  = 1'b0;
    ORDY  = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("reset BUSY", BUSY, 0);
    check("reset DONE", DONE, 0);
    check("reset ERR", ERR, 0);
    check("reset ERRCODE", ERRCODE, 0);
    check("reset IRDY", IRDY, 0);
    check("reset OVLD", OVLD, 0);
    check("reset ODAT", ODAT, 0);
    @(negedge CLK);
    RST = 1'b0;

    run("inc3", "+++.", 8'h00, 0, 0, c);
    check("inc3 first beat", first_xfer, 8'h03);
    check("inc3 start-to-ovld cycles", c, 1032);

    run("loop", "++[->+++<]>.", 8'h00, 0, 0, c);
    check("loop first beat", first_xfer, 8'h06);

    run("skip", "[+++]+.", 8'h00, 0, 0, c);
    check("skip first beat", first_xfer, 8'h01);

    run("io", ",+.", 8'h41, 5, 0, c);
    check("io first beat", first_xfer, 8'h42);
    check("io stalled cycles", stall_seen, 5);
    check("io single transfer", xfers, 1);

    run("dec", "-.", 8'h00, 0, 0, c);
    check("dec first beat", first_xfer, 8'hFF);

    run("dpwrap", "<+.", 8'h00, 0, 0, c);
    check("dpwrap first beat", first_xfer, 8'h01);

    run("cwe busy", "+.", 8'h00, 0, 1, c);
    check("cwe busy first beat", first_xfer, 8'h01);

    run("close", "+]", 8'h00, 0, 0, c);
    check("close errcode", ERRCODE, 2);

    run("open", "[", 8'h00, 0, 0, c);
    check("open errcode", ERRCODE, 3);

    run("nest", {"+", "[[[[[[[[[[[[["}, 8'h00, 0, 0, c);
`ifdef BFU_LOOPSTACK_EN
    check("nest errcode", ERRCODE, 1);
`else
    check("nest errcode", ERRCODE, 0);
`endif

    // Reset in the middle of an output handshake.
    load("+.");
    ORDY = 1'b0;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    for (int i = 0; i < 3000 && !OVLD; i++) @(negedge CLK);
    check("outwait reached", OVLD, 1);
    RST = 1'b1;
    @(negedge CLK);
    check("rst in outwait OVLD", OVLD, 0);
    check("rst in outwait BUSY", BUSY, 0);
    RST = 1'b0;
    ORDY = 1'b1;

    // Reset and start together: reset wins.
    @(negedge CLK);
    RST   = 1'b1;
    START = 1'b1;
    @(negedge CLK);
    RST   = 1'b0;
    START = 1'b0;
    check("rst+start BUSY", BUSY, 0);

    run("after reset", "+.", 8'h00, 0, 0, c);
    check("after reset first beat", first_xfer, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
